led_chaser: RTL and testbench
=============================

// Module: led_chaser
// PURPOSE
//   Parametrised LED pattern generator driven from the board clock. A prescaler
//   divides clk_in down to a step rate, and a pattern engine advances one step per tick.
//   Four run-time modes: rotate, bounce, fill-bar, blink. Direction is selectable, and
//   the block can pause and single-step. It sits between the clock/PLL output and the
//   board LED pins, and its polarity matches the board.
// PARAMETERS
//   WIDTH      8     number of LEDs (>=2)
//   DIV_MAX    2400  prescaler reload; step period = DIV_MAX+1 enabled clk_in cycles (>=0)
//   ACTIVE_LOW 1     1: led = ~p (lit LED drives 0); 0: led = p
// PORTS
//   clk_in  in   1      single clock, all state on posedge
//   rst_n   in   1      asynchronous, active-low reset
//   en      in   1      1: prescaler runs; 0: prescaler and pattern frozen
//   mode    in   2      00 rotate, 01 bounce, 10 fill, 11 blink
//   dir     in   1      0: toward LSB (right), 1: toward MSB (left); ignored in bounce/blink
//   step    in   1      manual advance, honoured only while en=0 (one step per cycle high)
//   led     out  WIDTH  LED pins, polarity per ACTIVE_LOW
//   tick    out  1      registered 1-cycle pulse in the same cycle led shows a new step
// BEHAVIOUR
//   - Internal state: p[WIDTH-1:0] (1=lit), cnt ($clog2(DIV_MAX+1), min 1 bit),
//     mode_q, bdir (bounce direction), tick.
//   - Reset (async, while rst_n=0): p=1<<(WIDTH-1), cnt=DIV_MAX, mode_q=00, bdir=right, tick=0.
//     For WIDTH=8/ACTIVE_LOW=1, led=8'h7F. Reset mid-operation aborts immediately.
//   - Seed per mode: rotate/bounce -> one-hot MSB; fill/blink -> all zeros.
//   - Mode change (mode != mode_q) has priority over everything else:
//     next edge sets mode_q=mode, p=seed(mode), cnt=DIV_MAX, bdir=right, tick=0.
//   - Prescaler, en=1: if cnt!=0, cnt decrements. If cnt==0, cnt reloads DIV_MAX and an
//     advance happens on that edge.
//     DIV_MAX=0 advances every enabled cycle.
//   - en=0: cnt and p hold. step=1 causes an advance on that edge; cnt is untouched.
//   - Advance: p<=next(p) and tick<=1 on the same edge. On all other edges tick<=0.
//     Latency from the cnt==0 edge to the new led value is 0 cycles; led is a registered
//     output.
//   - next(p) by mode:
//     rotate: dir=0 gives p>>1 with bit0 wrapping to MSB; dir=1 gives p<<1 with MSB
//       wrapping to bit0. dir is sampled at each advance.
//     bounce: single bit moves per bdir. At bit0 moving right, bdir flips and
//       next=bit1. At MSB moving left, bdir flips and next=bit WIDTH-2.
//       The period is 2*(WIDTH-1) steps.
//     fill: dir=0 gives (p>>1)|MSB; dir=1 gives (p<<1)|1. All-ones goes to all-zeros.
//       The period is WIDTH+1 steps.
//     blink: next = ~p.
//   - Rotate and bounce with a non-one-hot p cannot occur, because a mode change
//     always reseeds p.
//   - No combinational path from inputs to outputs.
// TESTING (WIDTH=8, DIV_MAX=3, ACTIVE_LOW=1)
//   1 Reset/rotate right: rst_n low asynchronously mid-run -> led=7F and tick=0 with no
//     clock edge. Release with en=1, mode=00, dir=0 -> led 7F,BF,DF,...,FE,7F, changing
//     every 4 cycles, with tick high exactly in each change cycle.
//   2 Rotate left: from p=80, dir=1 -> led FE,FD,FB,...,7F.
//     Flipping dir mid-run takes effect at the next advance only.
//   3 Bounce: mode=01 -> p=80,40,...,02,01,02,...,40,80, period 14 steps, with no
//     repeat at either end.
//   4 Fill: mode=10, dir=0 -> led FF,7F,3F,1F,...,01,00,FF. dir=1 -> FF,FE,FC,...,00,FF.
//   5 Pause/step/blink: mode=11, en=0 held 10 cycles -> led and cnt frozen, tick=0.
//     step pulsed 1 cycle -> exactly one toggle FF<->00 with one tick. en=1 resumes the
//     count from the frozen cnt.
//   6 Mode change mid-period: rotate at p=10 with cnt=2, switch to fill -> next edge
//     led=FF, tick=0, cnt=3. The first fill step comes 4 cycles later.
//     Repeat with DIV_MAX=0 -> a new step every cycle.

Source files
------------

// File: rtl/led_chaser_if.sv
// Control and LED-output bundle for the led_chaser pattern generator.
// The slave side (led_chaser) receives the controls and drives the LED pins.
interface led_chaser_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic [1:0]       mode;
   logic             dir;
   logic             step;
   logic [WIDTH-1:0] led;
   logic             tick;

   modport master (
      output en, mode, dir, step,
      input  led, tick
   );

   modport slave (
      input  en, mode, dir, step,
      output led, tick
   );
endinterface

// File: rtl/led_chaser.sv
// LED pattern generator: prescaler divides clk_in to a step rate and a pattern engine
// advances rotate/bounce/fill/blink patterns, with pause and single-step control.
module led_chaser #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DIV_MAX    = 2400,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input logic         clk_in,
   input logic         rst_n,
   led_chaser_if.slave bus
);
   localparam int unsigned     CW     = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
   localparam logic [CW-1:0]   RELOAD = CW'(DIV_MAX);
   localparam logic [WIDTH-1:0] MSB   = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      MODE_ROTATE = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_FILL   = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_t;

   typedef enum logic {
      BDIR_RIGHT = 1'b0,
      BDIR_LEFT  = 1'b1
   } bdir_t;

   logic [WIDTH-1:0] p_q,    p_n,    p_adv;
   logic [CW-1:0]    cnt_q,  cnt_n;
   mode_t            mode_q, mode_n, mode_in;
   bdir_t            bdir_q, bdir_n, bdir_adv;
   logic             tick_q, tick_n;
   logic             advance;

   assign mode_in = mode_t'(bus.mode);

   function automatic logic [WIDTH-1:0] seed(input mode_t m);
      return (m == MODE_ROTATE || m == MODE_BOUNCE) ? MSB : '0;
   endfunction

   // Pattern successor for the current mode; bdir only changes at the bounce ends.
   always_comb begin
      p_adv    = p_q;
      bdir_adv = bdir_q;
      case (mode_q)
         MODE_ROTATE: begin
            if (bus.dir) p_adv = {p_q[WIDTH-2:0], p_q[WIDTH-1]};
            else         p_adv = {p_q[0], p_q[WIDTH-1:1]};
         end
         MODE_BOUNCE: begin
            if (bdir_q == BDIR_RIGHT) begin
               if (p_q[0]) begin
                  p_adv    = p_q << 1;
                  bdir_adv = BDIR_LEFT;
               end else begin
                  p_adv    = p_q >> 1;
               end
            end else begin
               if (p_q[WIDTH-1]) begin
                  p_adv    = p_q >> 1;
                  bdir_adv = BDIR_RIGHT;
               end else begin
                  p_adv    = p_q << 1;
               end
            end
         end
         MODE_FILL: begin
            if (&p_q)        p_adv = '0;
            else if (bus.dir) p_adv = {p_q[WIDTH-2:0], 1'b1};
            else              p_adv = {1'b1, p_q[WIDTH-1:1]};
         end
         MODE_BLINK: p_adv = ~p_q;
         default:    p_adv = p_q;
      endcase
   end

   // Mode change wins over prescaler and step; it reseeds and restarts the period.
   always_comb begin
      p_n     = p_q;
      cnt_n   = cnt_q;
      mode_n  = mode_q;
      bdir_n  = bdir_q;
      tick_n  = 1'b0;
      advance = 1'b0;
      if (mode_in != mode_q) begin
         mode_n = mode_in;
         p_n    = seed(mode_in);
         cnt_n  = RELOAD;
         bdir_n = BDIR_RIGHT;
      end else begin
         if (bus.en) begin
            if (cnt_q == '0) begin
               cnt_n   = RELOAD;
               advance = 1'b1;
            end else begin
               cnt_n   = cnt_q - CW'(1);
            end
         end else if (bus.step) begin
            advance = 1'b1;
         end
         if (advance) begin
            p_n    = p_adv;
            bdir_n = bdir_adv;
            tick_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         p_q    <= MSB;
         cnt_q  <= RELOAD;
         mode_q <= MODE_ROTATE;
         bdir_q <= BDIR_RIGHT;
         tick_q <= 1'b0;
      end else begin
         p_q    <= p_n;
         cnt_q  <= cnt_n;
         mode_q <= mode_n;
         bdir_q <= bdir_n;
         tick_q <= tick_n;
      end
   end

   assign bus.led  = ACTIVE_LOW ? ~p_q : p_q;
   assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser: two instances (DIV_MAX=3 and DIV_MAX=0) share random stimulus and
// are checked every cycle against a position/phase based model plus literal pattern checks.
module tb_led_chaser;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       dir = 1'b0;
   logic       step = 1'b0;
   logic       checking = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_chaser_if #(.WIDTH(W)) bus0 ();
   led_chaser_if #(.WIDTH(W)) bus1 ();

   assign bus0.en = en;   assign bus1.en = en;
   assign bus0.mode = mode; assign bus1.mode = mode;
   assign bus0.dir = dir; assign bus1.dir = dir;
   assign bus0.step = step; assign bus1.step = step;

   led_chaser #(.WIDTH(W), .DIV_MAX(3), .ACTIVE_LOW(1'b1)) u_dut0 (
      .clk_in(clk), .rst_n(rst_n), .bus(bus0.slave));
   led_chaser #(.WIDTH(W), .DIV_MAX(0), .ACTIVE_LOW(1'b1)) u_dut1 (
      .clk_in(clk), .rst_n(rst_n), .bus(bus1.slave));

   // Model: rotate as a lit position, bounce as a phase 0..2(W-1)-1, fill/blink as a vector.
   int         div[2] = '{3, 0};
   int         m_cnt[2];
   int         m_pos[2];
   int         m_phase[2];
   logic [1:0] m_mode[2];
   logic [W-1:0] m_v[2];
   logic       m_tick[2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_mode[k] = 2'd0; m_pos[k] = W - 1; m_phase[k] = 0;
            m_v[k] = '0; m_cnt[k] = div[k]; m_tick[k] = 1'b0;
         end else begin
            bit adv;
            adv = 1'b0;
            m_tick[k] = 1'b0;
            if (mode != m_mode[k]) begin
               m_mode[k] = mode; m_pos[k] = W - 1; m_phase[k] = 0;
               m_v[k] = '0; m_cnt[k] = div[k];
            end else if (en) begin
               if (m_cnt[k] == 0) begin
                  m_cnt[k] = div[k]; adv = 1'b1;
               end else begin
                  m_cnt[k] = m_cnt[k] - 1;
               end
            end else if (step) begin
               adv = 1'b1;
            end
            if (adv) begin
               m_tick[k] = 1'b1;
               case (m_mode[k])
                  2'd0: m_pos[k] = dir ? (m_pos[k] + 1) % W : (m_pos[k] + W - 1) % W;
                  2'd1: m_phase[k] = (m_phase[k] + 1) % (2 * (W - 1));
                  2'd2: begin
                     if (m_v[k] == {W{1'b1}}) m_v[k] = '0;
                     else if (dir) m_v[k] = (m_v[k] << 1) | W'(1);
                     else          m_v[k] = (m_v[k] >> 1) | (W'(1) << (W - 1));
                  end
                  default: m_v[k] = ~m_v[k];
               endcase
            end
         end
      end
   end

   function automatic logic [W-1:0] exp_led(int k);
      int b;
      case (m_mode[k])
         2'd0: return ~(W'(1) << m_pos[k]);
         2'd1: begin
            b = (m_phase[k] <= W - 1) ? (W - 1 - m_phase[k]) : (m_phase[k] - (W - 1));
            return ~(W'(1) << b);
         end
         default: return ~m_v[k];
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("led0_model",  32'(bus0.led),  32'(exp_led(0)));
         chk("tick0_model", 32'(bus0.tick), 32'(m_tick[0]));
         chk("led1_model",  32'(bus1.led),  32'(exp_led(1)));
         chk("tick1_model", 32'(bus1.tick), 32'(m_tick[1]));
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk0(input string name, input logic [7:0] led_e, input logic tick_e);
      chk({name, "_led"},  32'(bus0.led),  32'(led_e));
      chk({name, "_tick"}, 32'(bus0.tick), 32'(tick_e));
   endtask

   initial begin
      #1 rst_n = 1'b0;
      checking = 1'b1;
      #20;
      @(posedge clk); #2;
      rst_n = 1'b1; en = 1'b1; mode = 2'b11;
      wait_edges(6);
      chk0("blink_pre_reset", 8'h00, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk0("async_reset", 8'h7F, 1'b0);
      chk("async_reset_led1", 32'(bus1.led), 32'h7F);
      mode = 2'b00; dir = 1'b0; en = 1'b1;
      wait_edges(1);
      rst_n = 1'b1;
      // rotate right
      wait_edges(3); chk0("rot_r_hold", 8'h7F, 1'b0);
      wait_edges(1); chk0("rot_r_1", 8'hBF, 1'b1);
      wait_edges(4); chk0("rot_r_2", 8'hDF, 1'b1);
      wait_edges(20); chk0("rot_r_7", 8'hFE, 1'b1);
      wait_edges(4); chk0("rot_r_wrap", 8'h7F, 1'b1);
      // rotate left
      dir = 1'b1;
      wait_edges(4); chk0("rot_l_1", 8'hFE, 1'b1);
      wait_edges(4); chk0("rot_l_2", 8'hFD, 1'b1);
      // bounce
      mode = 2'b01;
      wait_edges(1);  chk0("bounce_seed", 8'h7F, 1'b0);
      wait_edges(28); chk0("bounce_bit0", 8'hFE, 1'b1);
      wait_edges(4);  chk0("bounce_turn", 8'hFD, 1'b1);
      wait_edges(24); chk0("bounce_period", 8'h7F, 1'b1);
      wait_edges(4);  chk0("bounce_msb_turn", 8'hBF, 1'b1);
      // fill
      mode = 2'b10; dir = 1'b0;
      wait_edges(1);  chk0("fill_seed", 8'hFF, 1'b0);
      wait_edges(4);  chk0("fill_r_1", 8'h7F, 1'b1);
      wait_edges(4);  chk0("fill_r_2", 8'h3F, 1'b1);
      wait_edges(24); chk0("fill_r_full", 8'h00, 1'b1);
      wait_edges(4);  chk0("fill_r_clear", 8'hFF, 1'b1);
      dir = 1'b1;
      wait_edges(4);  chk0("fill_l_1", 8'hFE, 1'b1);
      wait_edges(4);  chk0("fill_l_2", 8'hFC, 1'b1);
      // blink, pause, step
      mode = 2'b11;
      wait_edges(1);  chk0("blink_seed", 8'hFF, 1'b0);
      en = 1'b0;
      wait_edges(10); chk0("pause", 8'hFF, 1'b0);
      step = 1'b1;
      wait_edges(1);  chk0("step", 8'h00, 1'b1);
      step = 1'b0;
      wait_edges(1);  chk0("step_once", 8'h00, 1'b0);
      en = 1'b1;
      wait_edges(3);  chk0("resume_hold", 8'h00, 1'b0);
      wait_edges(1);  chk0("resume_adv", 8'hFF, 1'b1);
      // mode change mid-period
      mode = 2'b00; dir = 1'b0;
      wait_edges(1);  chk0("rot_reseed", 8'h7F, 1'b0);
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 200 && !found; i++) begin
            wait_edges(1);
            if (bus0.led == 8'hEF && m_cnt[0] == 2) found = 1'b1;
         end
         chk("find_p10_cnt2", 32'(found), 32'd1);
      end
      mode = 2'b10;
      wait_edges(1); chk0("mc_fill_seed", 8'hFF, 1'b0);
      chk("mc_fill_seed_led1", 32'(bus1.led), 32'hFF);
      wait_edges(1); chk("div0_fill_1", 32'(bus1.led), 32'h7F);
      chk("div0_fill_1_tick", 32'(bus1.tick), 32'd1);
      wait_edges(1); chk("div0_fill_2", 32'(bus1.led), 32'h3F);
      wait_edges(1); chk0("mc_fill_wait", 8'hFF, 1'b0);
      wait_edges(1); chk0("mc_fill_first", 8'h7F, 1'b1);
      // random phase
      for (int c = 0; c < 3000; c++) begin
         en   = ($urandom % 8) != 0;
         step = $urandom % 2;
         if ($urandom % 16 == 0) dir = ~dir;
         if ($urandom % 64 == 0) mode = 2'($urandom % 4);
         if ($urandom % 500 == 0) begin
            #1 rst_n = 1'b0;
            wait_edges(1);
            rst_n = 1'b1;
         end
         wait_edges(1);
      end
      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
      $fatal(1, "timeout");
   end
endmodule
